// File: rtl/row_sum_extractor.sv
// Per-frame maximum row population counter for a binary pixel stream.
// The result is committed to the display outputs only during vertical blanking.
module row_sum_extractor #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned CW     = 11,
  parameter int unsigned RW     = 9
) (
  input  logic          dclk,
  input  logic          clr_n,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          pix_data,
  input  logic          pix_sof,
  input  logic          pix_eol,
  input  logic          vblank,
  output logic [CW-1:0] sumRowout,
  output logic [RW-1:0] maxRow,
  output logic          sum_update,
  output logic          frame_err
);

  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROW, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, acc_q, acc_d, max_q, max_d, sum_q, sum_d;
  logic [RW-1:0]   row_q, row_d, idx_q, idx_d, maxrow_q, maxrow_d;
  logic            upd_q, upd_d, err_q, err_d;

  logic            xfer, in_frame, restart, col_last, bad, row_end, frame_end, commit;
  logic [CW-1:0]   col_b, acc_b, max_b, tot;
  logic [RW-1:0]   row_b, idx_b;

  // A sof pixel always starts from a clean frame, whichever state accepted it.
  always_comb begin
    xfer      = pix_valid && pix_ready;
    in_frame  = xfer && (pix_sof || (state_q == S_ROW));
    restart   = xfer && pix_sof && (state_q == S_ROW);
    col_b     = pix_sof ? '0 : col_q;
    acc_b     = pix_sof ? '0 : acc_q;
    max_b     = pix_sof ? '0 : max_q;
    row_b     = pix_sof ? '0 : row_q;
    idx_b     = pix_sof ? '0 : idx_q;
    tot       = acc_b + CW'(pix_data);
    col_last  = (col_b == LAST_COL);
    bad       = in_frame && (col_last != pix_eol);
    row_end   = in_frame && col_last && pix_eol;
    frame_end = row_end && (row_b == LAST_ROW);
    commit    = (state_q == S_DONE) && vblank;
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ROW: begin
        if (bad)            state_d = S_IDLE;
        else if (frame_end) state_d = S_DONE;
        else if (in_frame)  state_d = S_ROW;
      end
      S_DONE:  if (vblank) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_ready = (state_q != S_DONE);
  end

  // Row accumulation, running maximum and commit.
  always_comb begin
    col_d    = col_q;
    acc_d    = acc_q;
    row_d    = row_q;
    max_d    = max_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    maxrow_d = maxrow_q;
    upd_d    = 1'b0;
    err_d    = err_q || bad || restart;
    if (bad) begin
      col_d = '0;
      acc_d = '0;
      row_d = '0;
    end else if (row_end) begin
      col_d = '0;
      acc_d = '0;
      row_d = frame_end ? '0 : row_b + RW'(1);
      max_d = max_b;
      idx_d = idx_b;
      if (tot > max_b) begin
        max_d = tot;
        idx_d = row_b;
      end
    end else if (in_frame) begin
      col_d = col_b + CW'(1);
      acc_d = tot;
      row_d = row_b;
      max_d = max_b;
      idx_d = idx_b;
    end
    if (commit) begin
      sum_d    = max_q;
      maxrow_d = idx_q;
      upd_d    = 1'b1;
    end
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      col_q    <= '0;
      acc_q    <= '0;
      row_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      maxrow_q <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      col_q    <= col_d;
      acc_q    <= acc_d;
      row_q    <= row_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      maxrow_q <= maxrow_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign sumRowout  = sum_q;
  assign maxRow     = maxrow_q;
  assign sum_update = upd_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_row_sum_extractor.sv
// Randomized bench for row_sum_extractor on a reduced 16x12 frame, checked
// every cycle against a frame-level model plus literal end-of-test expectations.
module tb_row_sum_extractor;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int CW = 5;
  localparam int RW = 4;

  logic          dclk, clr_n, pix_valid, pix_ready, pix_data, pix_sof, pix_eol, vblank;
  logic [CW-1:0] sumRowout;
  logic [RW-1:0] maxRow;
  logic          sum_update, frame_err;

  row_sum_extractor #(.WIDTH(W), .HEIGHT(H), .CW(CW), .RW(RW)) dut (
    .dclk(dclk), .clr_n(clr_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .vblank(vblank),
    .sumRowout(sumRowout), .maxRow(maxRow), .sum_update(sum_update), .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;
  bit vb_rand = 0;
  bit img [0:H-1][0:W-1];

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collect per-row populations, pick the first maximum at commit.
  bit m_in, m_pend, m_upd, m_err;
  int m_row, m_col, m_sum, m_idx;
  int sums [0:H-1];

  always @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      m_in = 0; m_pend = 0; m_upd = 0; m_err = 0;
      m_row = 0; m_col = 0; m_sum = 0; m_idx = 0;
      for (int r = 0; r < H; r++) sums[r] = 0;
    end else begin
      m_upd = 0;
      if (m_pend) begin
        if (vblank) begin
          int b, bi;
          b = 0; bi = 0;
          for (int r = 0; r < H; r++) if (sums[r] > b) begin b = sums[r]; bi = r; end
          m_sum = b; m_idx = bi; m_upd = 1; m_pend = 0;
        end
      end else if (pix_valid) begin
        if (pix_sof) begin
          if (m_in) m_err = 1;
          m_in = 1; m_row = 0; m_col = 0;
          for (int r = 0; r < H; r++) sums[r] = 0;
        end
        if (m_in) begin
          sums[m_row] += int'(pix_data);
          if (pix_eol != (m_col == W - 1)) begin
            m_err = 1; m_in = 0;
          end else if (pix_eol) begin
            if (m_row == H - 1) begin m_in = 0; m_pend = 1; end
            else begin m_row++; m_col = 0; end
          end else m_col++;
        end
      end
    end
  end

  always @(negedge dclk) begin
    check("pix_ready",  int'(pix_ready),  int'(!m_pend));
    check("sumRowout",  int'(sumRowout),  m_sum);
    check("maxRow",     int'(maxRow),     m_idx);
    check("sum_update", int'(sum_update), int'(m_upd));
    check("frame_err",  int'(frame_err),  int'(m_err));
  end

  task automatic put(input bit d, input bit s, input bit e);
    bit done;
    done = 0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge dclk);
      if (!pix_ready) begin
        pix_valid = 0; vblank = 1;
      end else if ($urandom_range(0, 4) == 0) begin
        pix_valid = 0; pix_data = 1'($urandom); pix_sof = 1'($urandom);
        pix_eol = 1'($urandom); vblank = vb_rand ? 1'($urandom) : 1'b0;
      end else begin
        pix_valid = 1; pix_data = d; pix_sof = s; pix_eol = e;
        vblank = vb_rand ? 1'($urandom) : 1'b0;
        done = 1;
      end
    end
    if (!done) check("put_timeout", 0, 1);
    else @(posedge dclk);
  endtask

  task automatic idle_in();
    @(negedge dclk);
    pix_valid = 0; pix_sof = 0; pix_eol = 0;
  endtask

  task automatic send_frame(input bit skip_first);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (!(skip_first && r == 0 && c == 0))
          put(img[r][c], (r == 0 && c == 0), (c == W - 1));
    idle_in();
  endtask

  // kind 1: early eol, 2: late/missing eol, 3: sof mid-frame (then returns)
  task automatic send_err(input int kind, input int er, input int ec);
    for (int r = 0; r <= er; r++)
      for (int c = 0; c < W; c++) begin
        if (r == er && c == ec) begin
          if (kind == 1)      put(img[r][c], 0, 1);
          else if (kind == 2) put(img[r][c], 0, 0);
          else                put(img[0][0], 1, 0);
          #1;
          return;
        end
        put(img[r][c], (r == 0 && c == 0), (c == W - 1));
      end
  endtask

  task automatic wait_commit(input string name);
    int k;
    @(negedge dclk);
    vblank = 1;
    for (k = 0; k < 10; k++) begin
      @(posedge dclk); #1;
      if (sum_update) break;
    end
    check({name, "_commit_latency"}, k, 0);
    @(negedge dclk);
    vblank = 0;
    check({name, "_ready_after"}, int'(pix_ready), 1);
  endtask

  task automatic fill(input int density);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = ($urandom_range(0, 99) < density);
  endtask

  task automatic fill_sparse(input int maxk);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) img[r][c] = 0;
      for (int k = $urandom_range(0, maxk); k > 0; k--) img[r][$urandom_range(0, W - 1)] = 1;
    end
  endtask

  initial begin
    clr_n = 0; pix_valid = 0; pix_data = 0; pix_sof = 0; pix_eol = 0; vblank = 0;
    repeat (3) @(negedge dclk);
    check("rst_sum", int'(sumRowout), 0);
    check("rst_row", int'(maxRow), 0);
    check("rst_ready", int'(pix_ready), 1);
    check("rst_err", int'(frame_err), 0);
    clr_n = 1;

    // row 10 holds 7 set pixels, every other row at most 3
    fill_sparse(3);
    for (int c = 0; c < W; c++) img[10][c] = (c >= 2 && c < 9);
    send_frame(0);
    repeat (3) @(negedge dclk);
    wait_commit("t1");
    check("t1_sum", int'(sumRowout), 7);
    check("t1_row", int'(maxRow), 10);

    // two full rows tie; earlier one wins; commit held off by vblank=0
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = (r == 5 || r == 9);
    send_frame(0);
    vblank = 0;
    repeat (50) @(negedge dclk);
    check("t2_hold_ready", int'(pix_ready), 0);
    check("t2_hold_sum", int'(sumRowout), 7);
    check("t2_hold_row", int'(maxRow), 10);
    wait_commit("t2");
    check("t2_sum", int'(sumRowout), 16);
    check("t2_row", int'(maxRow), 5);

    // short row, then a good frame with max 12 at row 3
    fill(50);
    send_err(1, 4, 9);
    check("t4_err", int'(frame_err), 1);
    check("t4_sum_kept", int'(sumRowout), 16);
    idle_in();
    fill_sparse(8);
    for (int c = 0; c < W; c++) img[3][c] = (c < 12);
    send_frame(0);
    wait_commit("t4");
    check("t4_sum", int'(sumRowout), 12);
    check("t4_row", int'(maxRow), 3);
    check("t4_err_sticky", int'(frame_err), 1);

    // sof restart mid-frame, the restarted frame completes
    fill(40);
    send_err(3, 7, 5);
    check("t5_err", int'(frame_err), 1);
    send_frame(1);
    wait_commit("t5");

    // long row, then random frames with random vblank
    vb_rand = 1;
    fill(50);
    send_err(2, 2, W - 1);
    idle_in();
    for (int f = 0; f < 4; f++) begin
      fill($urandom_range(5, 95));
      send_frame(0);
    end
    vb_rand = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 0;
    send_frame(0);
    wait_commit("t6");
    check("t6_zero_sum", int'(sumRowout), 0);
    check("t6_zero_row", int'(maxRow), 0);

    // reset mid-row, then sof-less pixels must not produce a frame
    for (int i = 0; i < 20; i++) put(1, (i == 0), ((i % W) == W - 1));
    @(negedge dclk);
    #2 clr_n = 0;
    #1;
    check("t7_sum", int'(sumRowout), 0);
    check("t7_row", int'(maxRow), 0);
    check("t7_upd", int'(sum_update), 0);
    check("t7_err", int'(frame_err), 0);
    check("t7_ready", int'(pix_ready), 1);
    @(negedge dclk);
    clr_n = 1;
    vb_rand = 1;
    for (int i = 0; i < 3 * W; i++) put(1, 0, ((i % W) == W - 1));
    idle_in();
    repeat (4) @(negedge dclk);
    check("t7_no_commit_sum", int'(sumRowout), 0);

    repeat (3) @(negedge dclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/row_sum_extractor.md
# row_sum_extractor

Streaming reduction stage that sits directly upstream of the 640x480 VGA renderer and produces its `sumRowin` value. It consumes a binary (foreground/background) segmentation pixel stream in raster order and counts set pixels per row. It tracks the largest row sum and the index of that row across each frame. The result is committed only while the display is in vertical blanking, so the rendered digit never changes mid-frame.

## Interface
Parameters:
- `WIDTH`, 640: pixels per row.
- `HEIGHT`, 480: rows per frame.
- `CW`, 11: row-sum width. Must satisfy 2^CW > WIDTH.
- `RW`, 9: row-index width. Must satisfy 2^RW >= HEIGHT.

Ports:
- `dclk`  in  1  pixel clock, 25 MHz. The stage shares this clock with the VGA timing block.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `pix_valid`  in  1  upstream pixel valid.
- `pix_ready`  out  1  stage can accept a pixel.
- `pix_data`  in  1  1 = foreground pixel.
- `pix_sof`  in  1  qualifies the first pixel of a frame (row 0, column 0).
- `pix_eol`  in  1  qualifies the last pixel of a row.
- `vblank`  in  1  display is outside the active vertical range. Driven from the VGA vertical counter.
- `sumRowout`  out  CW  maximum row sum of the last committed frame. Connects to `sumRowin` of the VGA block.
- `maxRow`  out  RW  index of the row holding that maximum.
- `sum_update`  out  1  one-cycle pulse on each commit.
- `frame_err`  out  1  sticky framing-error flag.

## Operation
- A transfer occurs on any `dclk` rising edge where `pix_valid` and `pix_ready` are both 1. Nothing else advances the state.
- States:
  - IDLE: `pix_ready`=1. A transfer with `pix_sof`=1 starts a frame and is counted as column 0 of row 0, and the state moves to ROW. A transfer without `pix_sof` is accepted and discarded.
  - ROW: `pix_ready`=1. Each transfer adds `pix_data` to the column count `rc` and the row sum `acc`.
  - DONE: `pix_ready`=0. A result is pending. When the state is DONE and `vblank`=1, the result is committed and the state returns to IDLE.
- End of row: a transfer with `pix_eol`=1 at column `WIDTH-1` completes the row.
  - The row total is `acc + pix_data`.
  - If the row total is strictly greater than the running maximum, the running maximum takes the row total and the running index takes the current row. Ties keep the earlier row.
  - `acc` and the column count clear, and the row index increments.
  - An end-of-row on row `HEIGHT-1` moves the state to DONE.
- The running maximum and running index are cleared at the start of every frame. They are copied to `sumRowout`/`maxRow` only on commit.
- Framing errors set `frame_err`. In every error case the committed outputs are left untouched.
  - Short row: `pix_eol`=1 at a column below `WIDTH-1`. The frame is aborted and the state goes to IDLE.
  - Long row: column `WIDTH-1` arrives without `pix_eol`. The frame is aborted and the state goes to IDLE.
  - `pix_sof`=1 in ROW at any position other than the start of a frame: the partial frame is discarded and a new frame restarts with this pixel as column 0 of row 0.
- `frame_err` clears only on reset.
- Arithmetic is unsigned.
  - `acc` never exceeds WIDTH, so no saturation is needed.
  - A frame of all-zero rows commits `sumRowout`=0 and `maxRow`=0.

## Timing
- Reset values (apply while `clr_n`=0, asynchronously):
  - state = IDLE, so `pix_ready`=1.
  - `sumRowout`=0, `maxRow`=0, `sum_update`=0, `frame_err`=0.
  - All internal counters = 0.
- `pix_ready` is decoded combinationally from the state register only. It never depends on `pix_valid`.
- Commit latency:
  - The final end-of-row transfer happens at edge N. The state is DONE from edge N.
  - If `vblank`=1 during the cycle after edge N, the commit happens at edge N+1.
  - From edge N+1, `sumRowout`/`maxRow` hold the new values and `sum_update`=1 for exactly one cycle. The state returns to IDLE at the same edge.
- If `vblank`=0, the state stays in DONE with `pix_ready`=0 and the old outputs held. This repeats indefinitely until `vblank` is 1.
- `sumRowout`/`maxRow` change only on the commit edge. They are stable for the whole active display.
- Error detection takes effect at the offending transfer edge: `frame_err` is 1 from that edge on.
- Reset mid-frame discards all partial state. Recovery needs a new `pix_sof`.
- Throughput: one pixel per cycle in ROW. There are no bubbles between rows or frames except the DONE wait.

## Test plan
- Full frame, row 100 with 7 set pixels, all other rows ≤3 → `sumRowout`=7, `maxRow`=100. `sum_update` pulses once, one cycle after the first `vblank`=1 cycle following the last transfer.
- Rows 5 and 9 both all-ones (640), all other rows 0 → `sumRowout`=640, `maxRow`=5.
- Hold `vblank`=0 for 50 cycles after the last end-of-row → `pix_ready`=0 and the outputs keep their previous frame's values. Raise `vblank` → commit at the next edge and `pix_ready` returns to 1.
- Frame with `pix_eol` at column 300 of row 20 → `frame_err`=1 at that edge and the outputs are unchanged. A following good frame (max 12 at row 3) commits 12/3 and `frame_err` stays 1.
- `pix_sof` reasserted at row 40 column 17 → `frame_err`=1 and counting restarts. The frame that follows completes normally and commits.
- `clr_n` pulsed low mid-row → all outputs read 0 immediately and `pix_ready`=1. Pixels sent without `pix_sof` afterwards are ignored, with no commit.
